oven_controller: RTL and testbench

OVEN_CONTROLLER -- requirements
Module: oven_controller

---
 rtl/oven_pkg.sv | 26 ++
 rtl/oven_thermal_model.sv | 33 +++
 rtl/oven_controller.sv | 174 +++++++++++++++++
 tb/tb_oven_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/oven_pkg.sv
// Shared types and limits for the oven controller slice: FSM state encoding,
// setpoint clamp range, heating ceiling and the default resting temperature.
package oven_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREHEAT = 3'd1,
        COOK    = 3'd2,
        PAUSE   = 3'd3,
        DONE    = 3'd4
    } oven_state_t;

    localparam int unsigned TEMP_MIN        = 300;
    localparam int unsigned TEMP_MAX        = 500;
    localparam int unsigned TEMP_CEIL       = 600;
    localparam int unsigned AMBIENT_DEFAULT = 70;

    function automatic logic [9:0] clamp_target(input logic [9:0] t);
        logic [9:0] r;
        r = t;
        if (t < 10'(TEMP_MIN)) r = 10'(TEMP_MIN);
        if (t > 10'(TEMP_MAX)) r = 10'(TEMP_MAX);
        return r;
    endfunction

endpackage

// File: rtl/oven_thermal_model.sv
// First-order oven temperature model: ramps while the heater is on, cools
// toward ambient otherwise, updating only on the time-base tick.
module oven_thermal_model
    import oven_pkg::*;
#(
    parameter int unsigned AMBIENT   = AMBIENT_DEFAULT,
    parameter int unsigned RAMP_STEP = 25,
    parameter int unsigned COOL_STEP = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       heater_on,
    output logic [9:0] cur_temp
);

    logic [10:0] heated;
    logic [9:0]  cooled;

    // Widened sum so the ceiling compare cannot wrap.
    always_comb begin
        heated = {1'b0, cur_temp} + 11'(RAMP_STEP);
        if (heated > 11'(TEMP_CEIL)) heated = 11'(TEMP_CEIL);
        if ({1'b0, cur_temp} < 11'(AMBIENT + COOL_STEP)) cooled = 10'(AMBIENT);
        else                                             cooled = cur_temp - 10'(COOL_STEP);
    end

    always_ff @(posedge clk) begin
        if (rst)       cur_temp <= 10'(AMBIENT);
        else if (tick) cur_temp <= heater_on ? heated[9:0] : cooled;
    end

endmodule

// File: rtl/oven_controller.sv
// Oven cook-cycle controller: preheat, timed cook with hysteresis heater
// control, door-interlock pause, and a buzzer phase on completion.
module oven_controller
    import oven_pkg::*;
#(
    parameter int unsigned AMBIENT    = AMBIENT_DEFAULT,
    parameter int unsigned RAMP_STEP  = 25,
    parameter int unsigned COOL_STEP  = 5,
    parameter int unsigned HYST       = 10,
    parameter int unsigned BUZZ_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       onOff,
    input  logic       tick,
    input  logic       start,
    input  logic       cancel,
    input  logic       door_open,
    input  logic [9:0] temp_set,
    input  logic [9:0] timer_set,
    output logic       heater_on,
    output logic [9:0] cur_temp,
    output logic [9:0] time_left,
    output logic [2:0] state,
    output logic       buzzer
);

    oven_state_t state_q, state_n;
    oven_state_t pause_q, pause_n;
    logic        heater_q, heater_n;
    logic        buzzer_q, buzzer_n;
    logic [9:0]  time_q, time_n;
    logic [9:0]  target_q, target_n;
    logic [7:0]  buzz_q, buzz_n;
    logic [7:0]  buzz_inc;
    logic [10:0] low_band;
    logic        at_target, below_band;

    oven_thermal_model #(
        .AMBIENT   (AMBIENT),
        .RAMP_STEP (RAMP_STEP),
        .COOL_STEP (COOL_STEP)
    ) u_thermal (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .heater_on (heater_q),
        .cur_temp  (cur_temp)
    );

    assign low_band   = {1'b0, target_q} - 11'(HYST);
    assign at_target  = cur_temp >= target_q;
    assign below_band = {1'b0, cur_temp} < low_band;
    assign buzz_inc   = buzz_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pause_q  <= PREHEAT;
            heater_q <= 1'b0;
            buzzer_q <= 1'b0;
            time_q   <= '0;
            target_q <= 10'(TEMP_MIN);
            buzz_q   <= '0;
        end else begin
            state_q  <= state_n;
            pause_q  <= pause_n;
            heater_q <= heater_n;
            buzzer_q <= buzzer_n;
            time_q   <= time_n;
            target_q <= target_n;
            buzz_q   <= buzz_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        pause_n  = pause_q;
        heater_n = heater_q;
        buzzer_n = buzzer_q;
        time_n   = time_q;
        target_n = target_q;
        buzz_n   = buzz_q;

        // Power-off and cancel both win over everything else; cancel in IDLE
        // also swallows a coincident start.
        if (!onOff || cancel) begin
            state_n  = IDLE;
            heater_n = 1'b0;
            buzzer_n = 1'b0;
            time_n   = '0;
            buzz_n   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    heater_n = 1'b0;
                    buzzer_n = 1'b0;
                    if (start && !door_open && timer_set != '0) begin
                        state_n  = PREHEAT;
                        target_n = clamp_target(temp_set);
                        time_n   = timer_set;
                        heater_n = 1'b1;
                    end
                end
                PREHEAT: begin
                    if (door_open) begin
                        state_n  = PAUSE;
                        pause_n  = PREHEAT;
                        heater_n = 1'b0;
                    end else if (at_target) begin
                        state_n  = COOK;
                        heater_n = 1'b0;
                    end else begin
                        heater_n = 1'b1;
                    end
                end
                COOK: begin
                    if (door_open) begin
                        state_n  = PAUSE;
                        pause_n  = COOK;
                        heater_n = 1'b0;
                    end else begin
                        if (at_target)       heater_n = 1'b0;
                        else if (below_band) heater_n = 1'b1;
                        if (tick) begin
                            if (time_q <= 10'd1) begin
                                time_n   = '0;
                                state_n  = DONE;
                                heater_n = 1'b0;
                                buzzer_n = 1'b1;
                                buzz_n   = '0;
                            end else begin
                                time_n = time_q - 10'd1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    heater_n = 1'b0;
                    if (!door_open) begin
                        state_n  = pause_q;
                        heater_n = (pause_q == PREHEAT) || below_band;
                    end
                end
                DONE: begin
                    heater_n = 1'b0;
                    buzzer_n = 1'b1;
                    if (tick) begin
                        if (buzz_inc >= 8'(BUZZ_TICKS)) begin
                            state_n  = IDLE;
                            buzzer_n = 1'b0;
                            buzz_n   = '0;
                            time_n   = '0;
                        end else begin
                            buzz_n = buzz_inc;
                        end
                    end
                end
                default: begin
                    state_n  = IDLE;
                    heater_n = 1'b0;
                    buzzer_n = 1'b0;
                    time_n   = '0;
                end
            endcase
        end
    end

    assign heater_on = heater_q;
    assign buzzer    = buzzer_q;
    assign time_left = time_q;
    assign state     = state_q;

endmodule

// File: tb/tb_oven_controller.sv
// Directed bench for oven_controller: normal cycle, clamping, door pause,
// hysteresis, aborts and start-rejection edge cases.
module tb_oven_controller;

    logic       clk = 1'b0;
    logic       rst, onOff, tick, start, cancel, door_open;
    logic [9:0] temp_set, timer_set;
    logic       heater_on, buzzer;
    logic [9:0] cur_temp, time_left;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_PRE = 3'd1, ST_COOK = 3'd2,
                           ST_PAUSE = 3'd3, ST_DONE = 3'd4;

    oven_controller #(
        .AMBIENT    (70),
        .RAMP_STEP  (25),
        .COOL_STEP  (5),
        .HYST       (10),
        .BUZZ_TICKS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .onOff     (onOff),
        .tick      (tick),
        .start     (start),
        .cancel    (cancel),
        .door_open (door_open),
        .temp_set  (temp_set),
        .timer_set (timer_set),
        .heater_on (heater_on),
        .cur_temp  (cur_temp),
        .time_left (time_left),
        .state     (state),
        .buzzer    (buzzer)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] t, input logic [9:0] n);
        temp_set  = t;
        timer_set = n;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (heater_on !== 1'b0) begin n_fail++; $display("FAIL reset_heater: got %b want 0", heater_on); end
        n_checks++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
        n_checks++; if (time_left !== 10'd0) begin n_fail++; $display("FAIL reset_time: got %0d want 0", time_left); end
        n_checks++; if (cur_temp !== 10'd70) begin n_fail++; $display("FAIL reset_temp: got %0d want 70", cur_temp); end
    endtask

    task automatic test_normal();
        do_reset();
        do_start(10'd350, 10'd3);
        n_checks++; if (state !== ST_PRE) begin n_fail++; $display("FAIL normal_preheat: got %0d want 1", state); end
        n_checks++; if (heater_on !== 1'b1) begin n_fail++; $display("FAIL normal_heat: got %b want 1", heater_on); end
        n_checks++; if (time_left !== 10'd3) begin n_fail++; $display("FAIL normal_load: got %0d want 3", time_left); end
        temp_set  = 10'd999;
        timer_set = 10'd9;
        ticks(12);
        n_checks++; if (cur_temp !== 10'd370) begin n_fail++; $display("FAIL normal_ramp: got %0d want 370", cur_temp); end
        n_checks++; if (state !== ST_PRE) begin n_fail++; $display("FAIL normal_still_pre: got %0d want 1", state); end
        cyc();
        n_checks++; if (state !== ST_COOK) begin n_fail++; $display("FAIL normal_cook: got %0d want 2", state); end
        n_checks++; if (heater_on !== 1'b0) begin n_fail++; $display("FAIL normal_cook_heat: got %b want 0", heater_on); end
        ticks(2);
        n_checks++; if (time_left !== 10'd1) begin n_fail++; $display("FAIL normal_countdown: got %0d want 1", time_left); end
        ticks(1);
        n_checks++; if (state !== ST_DONE) begin n_fail++; $display("FAIL normal_done: got %0d want 4", state); end
        n_checks++; if (buzzer !== 1'b1) begin n_fail++; $display("FAIL normal_buzz: got %b want 1", buzzer); end
        n_checks++; if (time_left !== 10'd0) begin n_fail++; $display("FAIL normal_time0: got %0d want 0", time_left); end
        n_checks++; if (cur_temp !== 10'd355) begin n_fail++; $display("FAIL normal_cool: got %0d want 355", cur_temp); end
        ticks(2);
        n_checks++; if (state !== ST_DONE || buzzer !== 1'b1) begin n_fail++; $display("FAIL normal_buzz_hold: got state=%0d buzz=%b want 4/1", state, buzzer); end
        ticks(1);
        n_checks++; if (state !== ST_IDLE || buzzer !== 1'b0) begin n_fail++; $display("FAIL normal_idle: got state=%0d buzz=%b want 0/0", state, buzzer); end
        n_checks++; if (cur_temp !== 10'd340) begin n_fail++; $display("FAIL normal_idle_cool: got %0d want 340", cur_temp); end
    endtask

    task automatic test_clamp();
        do_reset();
        do_start(10'd900, 10'd2);
        ticks(17);
        cyc();
        n_checks++; if (state !== ST_PRE || cur_temp !== 10'd495) begin n_fail++; $display("FAIL clamp_hi_below: got state=%0d temp=%0d want 1/495", state, cur_temp); end
        ticks(1);
        cyc();
        n_checks++; if (state !== ST_COOK) begin n_fail++; $display("FAIL clamp_hi_cook: got %0d want 2", state); end
        cancel = 1'b1; cyc(); cancel = 1'b0;
        do_reset();
        do_start(10'd100, 10'd2);
        ticks(9);
        cyc();
        n_checks++; if (state !== ST_PRE || cur_temp !== 10'd295) begin n_fail++; $display("FAIL clamp_lo_below: got state=%0d temp=%0d want 1/295", state, cur_temp); end
        ticks(1);
        cyc();
        n_checks++; if (state !== ST_COOK || cur_temp !== 10'd320) begin n_fail++; $display("FAIL clamp_lo_cook: got state=%0d temp=%0d want 2/320", state, cur_temp); end
        cancel = 1'b1; cyc(); cancel = 1'b0;
    endtask

    task automatic test_door();
        do_reset();
        do_start(10'd350, 10'd4);
        ticks(12);
        cyc();
        ticks(2);
        n_checks++; if (state !== ST_COOK || time_left !== 10'd2) begin n_fail++; $display("FAIL door_pre: got state=%0d time=%0d want 2/2", state, time_left); end
        door_open = 1'b1;
        ticks(1);
        n_checks++; if (state !== ST_PAUSE || time_left !== 10'd2 || cur_temp !== 10'd355) begin n_fail++; $display("FAIL door_tick_open: got state=%0d time=%0d temp=%0d want 3/2/355", state, time_left, cur_temp); end
        ticks(4);
        n_checks++; if (state !== ST_PAUSE || time_left !== 10'd2 || heater_on !== 1'b0) begin n_fail++; $display("FAIL door_frozen: got state=%0d time=%0d heat=%b want 3/2/0", state, time_left, heater_on); end
        n_checks++; if (cur_temp !== 10'd335) begin n_fail++; $display("FAIL door_cool: got %0d want 335", cur_temp); end
        door_open = 1'b0;
        cyc();
        n_checks++; if (state !== ST_COOK || heater_on !== 1'b1) begin n_fail++; $display("FAIL door_resume: got state=%0d heat=%b want 2/1", state, heater_on); end
        ticks(1);
        n_checks++; if (state !== ST_COOK || time_left !== 10'd1) begin n_fail++; $display("FAIL door_tick1: got state=%0d time=%0d want 2/1", state, time_left); end
        ticks(1);
        n_checks++; if (state !== ST_DONE || time_left !== 10'd0) begin n_fail++; $display("FAIL door_done: got state=%0d time=%0d want 4/0", state, time_left); end
        cancel = 1'b1; cyc(); cancel = 1'b0;
        n_checks++; if (state !== ST_IDLE || buzzer !== 1'b0) begin n_fail++; $display("FAIL done_cancel: got state=%0d buzz=%b want 0/0", state, buzzer); end
    endtask

    task automatic test_hysteresis();
        do_reset();
        do_start(10'd350, 10'd20);
        ticks(12);
        cyc();
        ticks(6);
        n_checks++; if (cur_temp !== 10'd340 || heater_on !== 1'b0) begin n_fail++; $display("FAIL hyst_band_edge: got temp=%0d heat=%b want 340/0", cur_temp, heater_on); end
        ticks(1);
        n_checks++; if (cur_temp !== 10'd335 || heater_on !== 1'b0) begin n_fail++; $display("FAIL hyst_below_seen: got temp=%0d heat=%b want 335/0", cur_temp, heater_on); end
        cyc();
        n_checks++; if (heater_on !== 1'b1) begin n_fail++; $display("FAIL hyst_on: got %b want 1", heater_on); end
        ticks(1);
        cyc();
        n_checks++; if (cur_temp !== 10'd360 || heater_on !== 1'b0) begin n_fail++; $display("FAIL hyst_off: got temp=%0d heat=%b want 360/0", cur_temp, heater_on); end
        n_checks++; if (time_left !== 10'd12) begin n_fail++; $display("FAIL hyst_time: got %0d want 12", time_left); end
        onOff = 1'b0;
        cyc();
        n_checks++; if (state !== ST_IDLE || heater_on !== 1'b0 || time_left !== 10'd0) begin n_fail++; $display("FAIL power_off: got state=%0d heat=%b time=%0d want 0/0/0", state, heater_on, time_left); end
        onOff = 1'b1;
    endtask

    task automatic test_abort();
        do_reset();
        do_start(10'd350, 10'd5);
        ticks(2);
        cancel = 1'b1; cyc(); cancel = 1'b0;
        n_checks++; if (state !== ST_IDLE || heater_on !== 1'b0 || time_left !== 10'd0) begin n_fail++; $display("FAIL cancel_preheat: got state=%0d heat=%b time=%0d want 0/0/0", state, heater_on, time_left); end
    endtask

    task automatic test_edges();
        do_reset();
        do_start(10'd350, 10'd0);
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL zero_timer: got %0d want 0", state); end
        door_open = 1'b1;
        do_start(10'd350, 10'd5);
        door_open = 1'b0;
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL door_start: got %0d want 0", state); end
        cancel = 1'b1;
        do_start(10'd350, 10'd5);
        cancel = 1'b0;
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL start_cancel: got %0d want 0", state); end
        do_start(10'd350, 10'd5);
        ticks(12);
        cyc();
        n_checks++; if (state !== ST_COOK) begin n_fail++; $display("FAIL rst_setup: got %0d want 2", state); end
        rst = 1'b1; cyc(); rst = 1'b0;
        cyc();
        n_checks++; if (state !== ST_IDLE || heater_on !== 1'b0 || buzzer !== 1'b0) begin n_fail++; $display("FAIL rst_cook_ctl: got state=%0d heat=%b buzz=%b want 0/0/0", state, heater_on, buzzer); end
        n_checks++; if (time_left !== 10'd0 || cur_temp !== 10'd70) begin n_fail++; $display("FAIL rst_cook_data: got time=%0d temp=%0d want 0/70", time_left, cur_temp); end
    endtask

    initial begin
        rst = 1'b0; onOff = 1'b1; tick = 1'b0; start = 1'b0; cancel = 1'b0;
        door_open = 1'b0; temp_set = '0; timer_set = '0;
        test_reset();
        test_normal();
        test_clamp();
        test_door();
        test_hysteresis();
        test_abort();
        test_edges();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
